// File: rtl/ift_sram_scrub_mem_pkg.sv
// Shared types for the scrubbing multi-taint IFT SRAM.
//   state_e    : sweep FSM states (INIT after reset, IDLE serving, SCRUB on request)
//   addr_width : word-address width for a given depth (at least 1 bit)
package ift_sram_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    SCRUB = 2'd2
  } state_e;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ift_sram_scrub_mem_if.sv
// Request/response bus of the IFT SRAM together with its per-taint shadow signals.
//   master : core-side adapter (drives request, write data and their taints)
//   slave  : memory side (drives gnt_o, rdata_o, rvalid_o, rdata_o_t0)
interface ift_sram_scrub_mem_if #(
  parameter int unsigned Width     = 64,
  parameter int unsigned Aw        = 10,
  parameter int unsigned NumTaints = 2
) ();

  logic                                req_i;
  logic                                gnt_o;
  logic                                write_i;
  logic [Aw-1:0]                       addr_i;
  logic [Width-1:0]                    wdata_i;
  logic [Width-1:0]                    wmask_i;
  logic [Width-1:0]                    rdata_o;
  logic                                rvalid_o;

  logic [NumTaints-1:0]                req_i_t0;
  logic [NumTaints-1:0]                write_i_t0;
  logic [NumTaints-1:0][Aw-1:0]        addr_i_t0;
  logic [NumTaints-1:0][Width-1:0]     wdata_i_t0;
  logic [NumTaints-1:0][Width-1:0]     wmask_i_t0;
  logic [NumTaints-1:0][Width-1:0]     rdata_o_t0;

  modport master (
    output req_i, write_i, addr_i, wdata_i, wmask_i,
    output req_i_t0, write_i_t0, addr_i_t0, wdata_i_t0, wmask_i_t0,
    input  gnt_o, rdata_o, rvalid_o, rdata_o_t0
  );

  modport slave (
    input  req_i, write_i, addr_i, wdata_i, wmask_i,
    input  req_i_t0, write_i_t0, addr_i_t0, wdata_i_t0, wmask_i_t0,
    output gnt_o, rdata_o, rvalid_o, rdata_o_t0
  );

endinterface

// File: rtl/ift_sram_scrub_mem_taint_bank.sv
// One taint channel: shadow taint array, sticky fully-tainted flag, response taint.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   clr_i, clr_addr_i : sweep write of zero to one taint word
//   clr_flag_i        : clear the sticky flag (last sweep cycle)
//   acc_i, write_i    : accepted request and its direction
//   addr_i, wmask_i   : request address and data write mask
//   req_t_i .. wmask_t_i : this channel's request taints
//   rtaint_o          : read-data taint seen by the core
//   flag_o            : sticky fully-tainted flag
module ift_sram_taint_bank #(
  parameter int unsigned Width            = 64,
  parameter int unsigned Depth            = 1024,
  parameter int unsigned Aw               = 10,
  parameter int unsigned ConservativeMode = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [Aw-1:0]    clr_addr_i,
  input  logic             clr_flag_i,
  input  logic             acc_i,
  input  logic             write_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [Width-1:0] wmask_i,
  input  logic             req_t_i,
  input  logic             write_t_i,
  input  logic [Aw-1:0]    addr_t_i,
  input  logic [Width-1:0] wdata_t_i,
  input  logic [Width-1:0] wmask_t_i,
  output logic [Width-1:0] rtaint_o,
  output logic             flag_o
);

  localparam logic Cm = (ConservativeMode != 0);

  logic [Width-1:0] taint_q [Depth];
  logic [Width-1:0] rd_q;
  logic             resp_q;
  logic             flag_q;
  logic [Width-1:0] merged_c;
  logic             set_flag_c;

  // Tainted mask bits force taint; otherwise written bits take the data taint.
  assign merged_c   = wmask_t_i | (wmask_i & wdata_t_i) | (~wmask_i & taint_q[addr_i]);
  assign set_flag_c = Cm & acc_i & (write_i | write_t_i) & (|addr_t_i);

  // Taint array: sweep clear, write merge, or tainted-direction read poisoning.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      taint_q[clr_addr_i] <= '0;
    end else if (acc_i && write_i) begin
      taint_q[addr_i] <= merged_c;
    end else if (acc_i && write_t_i) begin
      taint_q[addr_i] <= '1;
    end
  end

  // Response taint and sticky flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q   <= '0;
      resp_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      if (acc_i && !write_i) begin
        rd_q   <= taint_q[addr_i];
        resp_q <= (|addr_t_i) | req_t_i | write_t_i;
      end
      if (clr_flag_i) begin
        flag_q <= 1'b0;
      end else if (set_flag_c) begin
        flag_q <= 1'b1;
      end
    end
  end

  // The flag poisons the returned taint on every cycle, not only valid ones.
  assign rtaint_o = rd_q | {Width{resp_q | flag_q}};
  assign flag_o   = flag_q;

endmodule

// File: rtl/ift_sram_scrub_mem.sv
// Single-port IFT SRAM with per-taint shadow arrays and a scrub engine.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   bus             : request/response bus with taints (slave side)
//   scrub_req_i     : start a scrub of the channels in scrub_mask_i
//   scrub_busy_o    : sweep in progress (INIT or SCRUB)
//   scrub_done_o    : one-cycle pulse when any sweep completes
//   fully_tainted_o : sticky per-taint conservative flags
module ift_sram_scrub_mem
  import ift_sram_pkg::*;
#(
  parameter int unsigned Width            = 64,
  parameter int unsigned Depth            = 1024,
  parameter int unsigned NumTaints        = 2,
  parameter int unsigned ConservativeMode = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  ift_sram_scrub_mem_if.slave  bus,
  input  logic                 scrub_req_i,
  input  logic [NumTaints-1:0] scrub_mask_i,
  output logic                 scrub_busy_o,
  output logic                 scrub_done_o,
  output logic [NumTaints-1:0] fully_tainted_o
);

  localparam int unsigned Aw = addr_width(Depth);
  typedef logic [Aw-1:0] cnt_t;
  localparam cnt_t LastCnt = cnt_t'(Depth - 1);

  state_e               state_q;
  cnt_t                 cnt_q;
  logic [NumTaints-1:0] mask_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 rvalid_q;
  logic [Width-1:0]     rdata_q;
  logic [Width-1:0]     mem_q [Depth];

  logic                 gnt_c;
  logic                 acc_c;
  logic                 sweep_c;
  logic                 last_c;
  logic [NumTaints-1:0] clr_sel_c;

  logic [NumTaints-1:0][Aw-1:0]    addr_t;
  logic [NumTaints-1:0][Width-1:0] wdata_t;
  logic [NumTaints-1:0][Width-1:0] wmask_t;
  logic [NumTaints-1:0][Width-1:0] rtaint;
  logic [NumTaints-1:0]            flags;

  // A scrub request takes priority over a same-cycle memory request.
  assign gnt_c     = (state_q == IDLE) & ~scrub_req_i;
  assign acc_c     = bus.req_i & gnt_c;
  assign sweep_c   = (state_q != IDLE);
  assign last_c    = sweep_c & (cnt_q == LastCnt);
  assign clr_sel_c = (state_q == INIT) ? '1 : mask_q;

  // Sweep FSM: INIT clears every channel, SCRUB only the latched mask.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        INIT, SCRUB: begin
          if (cnt_q == LastCnt) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end
        IDLE: begin
          if (scrub_req_i) begin
            state_q <= SCRUB;
            mask_q  <= scrub_mask_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= INIT;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Data array is never reset; contents survive reset and scrub.
  always_ff @(posedge clk_i) begin
    if (acc_c && bus.write_i) begin
      mem_q[bus.addr_i] <= (mem_q[bus.addr_i] & ~bus.wmask_i) | (bus.wdata_i & bus.wmask_i);
    end
  end

  // Read response: one-cycle latency, data holds between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= acc_c & ~bus.write_i;
      if (acc_c && !bus.write_i) begin
        rdata_q <= mem_q[bus.addr_i];
      end
    end
  end

  assign addr_t  = bus.addr_i_t0;
  assign wdata_t = bus.wdata_i_t0;
  assign wmask_t = bus.wmask_i_t0;

  for (genvar g = 0; g < int'(NumTaints); g++) begin : g_bank
    ift_sram_taint_bank #(
      .Width           (Width),
      .Depth           (Depth),
      .Aw              (Aw),
      .ConservativeMode(ConservativeMode)
    ) u_bank (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (sweep_c & clr_sel_c[g]),
      .clr_addr_i(cnt_q),
      .clr_flag_i(last_c & clr_sel_c[g]),
      .acc_i     (acc_c),
      .write_i   (bus.write_i),
      .addr_i    (bus.addr_i),
      .wmask_i   (bus.wmask_i),
      .req_t_i   (bus.req_i_t0[g]),
      .write_t_i (bus.write_i_t0[g]),
      .addr_t_i  (addr_t[g]),
      .wdata_t_i (wdata_t[g]),
      .wmask_t_i (wmask_t[g]),
      .rtaint_o  (rtaint[g]),
      .flag_o    (flags[g])
    );
  end

  assign bus.gnt_o      = gnt_c;
  assign bus.rvalid_o   = rvalid_q;
  assign bus.rdata_o    = rdata_q;
  assign bus.rdata_o_t0 = rtaint;
  assign scrub_busy_o   = busy_q;
  assign scrub_done_o   = done_q;
  assign fully_tainted_o = flags;

endmodule

// File: tb/tb_ift_sram_scrub_mem.sv
// Self-checking bench: two instances (conservative on/off) share one stimulus stream,
// checked against a word-level reference model of data, taints and sticky flags.
module tb_ift_sram_scrub_mem;

  localparam int unsigned W  = 64;
  localparam int unsigned D  = 1024;
  localparam int unsigned NT = 2;
  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          scrub_req;
  logic [NT-1:0] scrub_mask;
  logic          busy0, done0, busy1, done1;
  logic [NT-1:0] ft0, ft1;

  ift_sram_scrub_mem_if #(.Width(W), .Aw(AW), .NumTaints(NT)) bus0 ();
  ift_sram_scrub_mem_if #(.Width(W), .Aw(AW), .NumTaints(NT)) bus1 ();

  assign bus1.req_i      = bus0.req_i;
  assign bus1.write_i    = bus0.write_i;
  assign bus1.addr_i     = bus0.addr_i;
  assign bus1.wdata_i    = bus0.wdata_i;
  assign bus1.wmask_i    = bus0.wmask_i;
  assign bus1.req_i_t0   = bus0.req_i_t0;
  assign bus1.write_i_t0 = bus0.write_i_t0;
  assign bus1.addr_i_t0  = bus0.addr_i_t0;
  assign bus1.wdata_i_t0 = bus0.wdata_i_t0;
  assign bus1.wmask_i_t0 = bus0.wmask_i_t0;

  ift_sram_scrub_mem #(.Width(W), .Depth(D), .NumTaints(NT), .ConservativeMode(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0.slave), .scrub_req_i(scrub_req),
    .scrub_mask_i(scrub_mask), .scrub_busy_o(busy0), .scrub_done_o(done0),
    .fully_tainted_o(ft0));

  ift_sram_scrub_mem #(.Width(W), .Depth(D), .NumTaints(NT), .ConservativeMode(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1.slave), .scrub_req_i(scrub_req),
    .scrub_mask_i(scrub_mask), .scrub_busy_o(busy1), .scrub_done_o(done1),
    .fully_tainted_o(ft1));

  int tests = 0;
  int fails = 0;

  // Reference model
  logic [W-1:0]  data_m  [D];
  logic [W-1:0]  known_m [D];
  logic [W-1:0]  taint_m [NT][D];
  logic [NT-1:0] flag_m;
  logic [W-1:0]  exp_rdata, exp_known;
  logic [W-1:0]  base_m [NT];
  logic [NT-1:0] resp_m;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus0.req_i      = 1'b0;
    bus0.write_i    = 1'b0;
    bus0.addr_i     = '0;
    bus0.wdata_i    = '0;
    bus0.wmask_i    = '0;
    bus0.req_i_t0   = '0;
    bus0.write_i_t0 = '0;
    bus0.addr_i_t0  = '0;
    bus0.wdata_i_t0 = '0;
    bus0.wmask_i_t0 = '0;
  endtask

  // Effect of reset + INIT sweep: taints and flags cleared, outputs zero, data kept.
  task automatic model_reset();
    for (int t = 0; t < int'(NT); t++) begin
      for (int a = 0; a < int'(D); a++) taint_m[t][a] = '0;
      base_m[t] = '0;
    end
    flag_m    = '0;
    resp_m    = '0;
    exp_rdata = '0;
    exp_known = '1;
  endtask

  task automatic check_outputs(input string tag);
    logic [W-1:0] e0, e1;
    chk({tag, "_rdata0"}, bus0.rdata_o & exp_known, exp_rdata & exp_known);
    chk({tag, "_rdata1"}, bus1.rdata_o & exp_known, exp_rdata & exp_known);
    for (int t = 0; t < int'(NT); t++) begin
      e0 = base_m[t] | {W{resp_m[t] | flag_m[t]}};
      e1 = base_m[t] | {W{resp_m[t]}};
      chk($sformatf("%s_rt0_%0d", tag, t), bus0.rdata_o_t0[t], e0);
      chk($sformatf("%s_rt1_%0d", tag, t), bus1.rdata_o_t0[t], e1);
    end
    chk({tag, "_ft0"}, ft0, flag_m);
    chk({tag, "_ft1"}, ft1, '0);
  endtask

  task automatic op(input logic wr, input logic [AW-1:0] a,
                    input logic [W-1:0] wd, input logic [W-1:0] wm,
                    input logic [NT-1:0] rq_t, input logic [NT-1:0] wr_t,
                    input logic [NT-1:0][AW-1:0] a_t,
                    input logic [NT-1:0][W-1:0] wd_t,
                    input logic [NT-1:0][W-1:0] wm_t,
                    input string tag);
    bus0.req_i      = 1'b1;
    bus0.write_i    = wr;
    bus0.addr_i     = a;
    bus0.wdata_i    = wd;
    bus0.wmask_i    = wm;
    bus0.req_i_t0   = rq_t;
    bus0.write_i_t0 = wr_t;
    bus0.addr_i_t0  = a_t;
    bus0.wdata_i_t0 = wd_t;
    bus0.wmask_i_t0 = wm_t;
    #1;
    chk({tag, "_gnt"}, bus0.gnt_o, 1'b1);
    if (wr) begin
      data_m[a]  = (data_m[a] & ~wm) | (wd & wm);
      known_m[a] = known_m[a] | wm;
    end
    for (int t = 0; t < int'(NT); t++) begin
      for (int i = 0; i < int'(W); i++) begin
        if (wr) begin
          if (wm_t[t][i])   taint_m[t][a][i] = 1'b1;
          else if (wm[i])   taint_m[t][a][i] = wd_t[t][i];
        end else if (wr_t[t]) begin
          taint_m[t][a][i] = 1'b1;
        end
      end
      if ((wr || wr_t[t]) && (a_t[t] != '0)) flag_m[t] = 1'b1;
    end
    if (!wr) begin
      exp_rdata = data_m[a];
      exp_known = known_m[a];
      for (int t = 0; t < int'(NT); t++) begin
        base_m[t] = taint_m[t][a];
        resp_m[t] = (a_t[t] != '0) || rq_t[t] || wr_t[t];
      end
    end
    tick();
    idle_inputs();
    chk({tag, "_rvalid0"}, bus0.rvalid_o, !wr);
    chk({tag, "_rvalid1"}, bus1.rvalid_o, !wr);
    if (!wr) check_outputs(tag);
  endtask

  task automatic wait_gnt(input string tag);
    int n = 0;
    while (!bus0.gnt_o && n < int'(D) + 8) begin
      tick();
      n++;
    end
    chk({tag, "_len"}, n, D);
    chk({tag, "_done0"}, done0, 1'b1);
    chk({tag, "_done1"}, done1, 1'b1);
    chk({tag, "_busy0"}, busy0, 1'b0);
    chk({tag, "_gnt1"}, bus1.gnt_o, 1'b1);
    tick();
    chk({tag, "_done_pulse"}, done0, 1'b0);
  endtask

  initial begin
    logic [NT-1:0][AW-1:0] at;
    logic [NT-1:0][W-1:0]  wdt, wmt;
    logic                  wr;
    int                    n;

    for (int a = 0; a < int'(D); a++) begin
      data_m[a]  = '0;
      known_m[a] = '0;
    end
    rst        = 1'b1;
    scrub_req  = 1'b0;
    scrub_mask = '0;
    idle_inputs();
    repeat (3) tick();

    // Reset values
    chk("rst_gnt", bus0.gnt_o, 1'b0);
    chk("rst_rvalid", bus0.rvalid_o, 1'b0);
    chk("rst_busy", busy0, 1'b1);
    chk("rst_done", done0, 1'b0);
    chk("rst_rdata", bus0.rdata_o, '0);
    chk("rst_rt0", bus0.rdata_o_t0, '0);
    chk("rst_ft", ft0, '0);

    // INIT sweep length
    rst = 1'b0;
    model_reset();
    wait_gnt("init");

    for (int k = 0; k < 4; k++)
      op(1'b0, AW'($urandom_range(0, D - 1)), '0, '0, '0, '0, '0, '0, '0, "init_rd");

    // Directed write/read of address 5
    wdt = '0;
    wdt[0] = 64'h0F;
    op(1'b1, 10'd5, 64'hA5, 64'hFF, '0, '0, '0, wdt, '0, "wr5");
    op(1'b0, 10'd5, '0, '0, '0, '0, '0, '0, '0, "rd5");
    tick();
    chk("hold_rvalid", bus0.rvalid_o, 1'b0);
    check_outputs("hold");

    // Randomized traffic, no address taint
    for (int k = 0; k < 300; k++) begin
      wr  = 1'($urandom_range(0, 1));
      wdt = {$urandom, $urandom, $urandom, $urandom};
      wmt = {$urandom & $urandom, $urandom & $urandom, $urandom & $urandom, $urandom & $urandom};
      op(wr, AW'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
         NT'($urandom), ($urandom_range(0, 7) == 0) ? NT'($urandom) : '0, '0, wdt, wmt, "rnd");
      if ($urandom_range(0, 4) == 0) begin
        tick();
        chk("rnd_idle_rvalid", bus0.rvalid_o, 1'b0);
        check_outputs("rnd_idle");
      end
    end

    // Tainted-address read, then untainted read of the same word
    at = '0;
    at[0] = 10'd1;
    op(1'b0, 10'd5, '0, '0, '0, '0, at, '0, '0, "rd_atnt");
    op(1'b0, 10'd5, '0, '0, '0, '0, '0, '0, '0, "rd_clean");

    // Write through a tainted address sets the sticky flag (conservative instance only)
    at = '0;
    at[1] = 10'd3;
    op(1'b1, 10'd7, 64'h1234, '1, '0, '0, at, '0, '0, "wr_atnt");
    chk("sticky_ft0", ft0, 2'b10);
    chk("sticky_ft1", ft1, 2'b00);
    tick();
    check_outputs("sticky_idle");
    op(1'b0, 10'd7, '0, '0, '0, '0, '0, '0, '0, "sticky_rd7");
    op(1'b0, 10'd5, '0, '0, '0, '0, '0, '0, '0, "sticky_rd5");

    // Scrub of taint 1 wins over a same-cycle write
    scrub_req  = 1'b1;
    scrub_mask = 2'b10;
    bus0.req_i   = 1'b1;
    bus0.write_i = 1'b1;
    bus0.addr_i  = 10'd5;
    bus0.wdata_i = '1;
    bus0.wmask_i = '1;
    bus0.wmask_i_t0 = '1;
    #1;
    chk("scrub_gnt0", bus0.gnt_o, 1'b0);
    chk("scrub_gnt1", bus1.gnt_o, 1'b0);
    tick();
    scrub_req = 1'b0;
    scrub_mask = '0;
    idle_inputs();
    chk("scrub_busy0", busy0, 1'b1);
    chk("scrub_busy1", busy1, 1'b1);
    n = 0;
    while (!done0 && n < int'(D) + 8) begin
      tick();
      n++;
    end
    chk("scrub_len", n, D);
    chk("scrub_gnt", bus0.gnt_o, 1'b1);
    chk("scrub_busy_end", busy0, 1'b0);
    for (int a = 0; a < int'(D); a++) taint_m[1][a] = '0;
    flag_m[1] = 1'b0;
    chk("scrub_ft0", ft0, flag_m);
    op(1'b0, 10'd5, '0, '0, '0, '0, '0, '0, '0, "post_scrub_rd5");
    op(1'b0, 10'd7, '0, '0, '0, '0, '0, '0, '0, "post_scrub_rd7");

    // Reset in the middle of a scrub restarts the full INIT sweep
    scrub_req  = 1'b1;
    scrub_mask = 2'b01;
    tick();
    scrub_req  = 1'b0;
    scrub_mask = '0;
    repeat (37) tick();
    chk("mid_busy", busy0, 1'b1);
    rst = 1'b1;
    tick();
    chk("mid_rst_rvalid", bus0.rvalid_o, 1'b0);
    chk("mid_rst_busy", busy0, 1'b1);
    chk("mid_rst_gnt", bus0.gnt_o, 1'b0);
    rst = 1'b0;
    model_reset();
    wait_gnt("reinit");
    op(1'b0, 10'd5, '0, '0, '0, '0, '0, '0, '0, "reinit_rd5");
    op(1'b0, 10'd7, '0, '0, '0, '0, '0, '0, '0, "reinit_rd7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
